// File: rtl/verin_pkg.sv
// Shared definitions for the tiller actuator (verin) PWM controller: register map,
// state encoding and STATUS word layout.
package verin_pkg;

  localparam logic [1:0] ADDR_PERIOD = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DEAD    = 2'd1,
    ST_RUN     = 2'd2,
    ST_BLOCKED = 2'd3
  } state_e;

  // STATUS bit positions, also consumed by the C header generator
  localparam int STAT_POS_LSB   = 0;
  localparam int STAT_POS_MSB   = 11;
  localparam int STAT_AT_MIN    = 12;
  localparam int STAT_AT_MAX    = 13;
  localparam int STAT_STATE_LSB = 14;
  localparam int STAT_STATE_MSB = 15;

  function automatic logic [31:0] pack_status(input logic [11:0] pos, input logic at_min,
                                              input logic at_max, input state_e st);
    logic [31:0] word;
    word = 32'd0;
    word[STAT_POS_MSB:STAT_POS_LSB]     = pos;
    word[STAT_AT_MIN]                   = at_min;
    word[STAT_AT_MAX]                   = at_max;
    word[STAT_STATE_MSB:STAT_STATE_LSB] = st;
    return word;
  endfunction

endpackage

// File: rtl/verin_pwm_gen.sv
// PWM generator: free-running period counter with shadowed period/duty so a new
// setpoint only takes effect at a period boundary.
module verin_pwm_gen (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        run_i,
  input  logic [15:0] period_i,
  input  logic [15:0] duty_i,
  output logic        pwm_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] period_sh_q, period_sh_d;
  logic [15:0] duty_sh_q, duty_sh_d;
  logic        pwm_q, pwm_d;
  logic        wrap_s;

  // A zero period never wraps on its own, so it is treated as a wrap every cycle
  // to let a newly written period be picked up.
  always_comb begin
    wrap_s      = (period_sh_q == 16'd0) || (cnt_q == (period_sh_q - 16'd1));
    cnt_d       = cnt_q;
    period_sh_d = period_sh_q;
    duty_sh_d   = duty_sh_q;
    pwm_d       = 1'b0;
    if (!run_i) begin
      cnt_d       = 16'd0;
      period_sh_d = period_i;
      duty_sh_d   = duty_i;
      pwm_d       = 1'b0;
    end else begin
      pwm_d = (period_sh_q != 16'd0) && (cnt_q < duty_sh_q);
      if (wrap_s) begin
        cnt_d       = 16'd0;
        period_sh_d = period_i;
        duty_sh_d   = duty_i;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Counter, shadow and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 16'd0;
      period_sh_q <= 16'd0;
      duty_sh_q   <= 16'd0;
      pwm_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      period_sh_q <= period_sh_d;
      duty_sh_q   <= duty_sh_d;
      pwm_q       <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/verin_pwm_ctrl.sv
// Avalon-MM slave sequencing the tiller H-bridge: register file, direction/dead-time
// state machine and end-of-stroke blocking from the ADC position.
module verin_pwm_ctrl
  import verin_pkg::*;
#(
  parameter int          DEAD_CYCLES = 50,
  parameter logic [11:0] POS_MIN     = 12'd200,
  parameter logic [11:0] POS_MAX     = 12'd3900
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [11:0] position,
  input  logic        pos_valid,
  output logic        pwm_out,
  output logic        sens_out,
  output logic        butee_irq
);

  localparam int DEAD_W = $clog2(DEAD_CYCLES + 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  logic [15:0]       period_q, period_d;
  logic [15:0]       duty_q, duty_d;
  logic              enable_q, enable_d;
  logic              sens_req_q, sens_req_d;
  logic              sens_req_prev_q;
  logic [11:0]       pos_q, pos_d;
  logic              at_min_q, at_min_d;
  logic              at_max_q, at_max_d;
  state_e            state_q, state_d;
  logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
  logic              sens_out_q, sens_out_d;
  logic              butee_q;
  logic [31:0]       readdata_q, readdata_d;
  logic              wr_en_s;
  logic              stop_hit_s;
  logic              run_s;
  logic              unused_wdata_s;

  assign wr_en_s        = chipselect && !write_n;
  assign unused_wdata_s = ^writedata[31:16];

  // Register file writes and position latch
  always_comb begin
    period_d   = period_q;
    duty_d     = duty_q;
    enable_d   = enable_q;
    sens_req_d = sens_req_q;
    if (wr_en_s) begin
      case (address)
        ADDR_PERIOD: period_d = writedata[15:0];
        ADDR_DUTY:   duty_d   = writedata[15:0];
        ADDR_CTRL: begin
          enable_d   = writedata[0];
          sens_req_d = writedata[1];
        end
        default: period_d = period_q;
      endcase
    end else begin
      period_d = period_q;
    end
    if (pos_valid) begin
      pos_d    = position;
      at_min_d = (position <= POS_MIN);
      at_max_d = (position >= POS_MAX);
    end else begin
      pos_d    = pos_q;
      at_min_d = at_min_q;
      at_max_d = at_max_q;
    end
  end

  // Sequencer; priority is enable=0, then end-stop, then direction change
  always_comb begin
    state_d    = state_q;
    dead_cnt_d = dead_cnt_q;
    sens_out_d = sens_out_q;
    stop_hit_s = (sens_out_q && at_max_q) || (!sens_out_q && at_min_q);
    case (state_q)
      ST_IDLE: begin
        if (enable_q) begin
          sens_out_d = sens_req_q;
          dead_cnt_d = DEAD_W'(0);
          state_d    = ST_DEAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DEAD: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (sens_req_q != sens_req_prev_q) begin
          dead_cnt_d = DEAD_W'(0);
        end else if (dead_cnt_q == DEAD_LAST) begin
          sens_out_d = sens_req_q;
          state_d    = ST_RUN;
        end else begin
          dead_cnt_d = dead_cnt_q + DEAD_W'(1);
        end
      end
      ST_RUN: begin
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (stop_hit_s) begin
          state_d = ST_BLOCKED;
        end else if (sens_req_q != sens_out_q) begin
          dead_cnt_d = DEAD_W'(0);
          state_d    = ST_DEAD;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_BLOCKED: begin
        // Only a request pointing away from the active stop releases the block
        if (!enable_q) begin
          state_d = ST_IDLE;
        end else if (sens_req_q != sens_out_q) begin
          dead_cnt_d = DEAD_W'(0);
          state_d    = ST_DEAD;
        end else begin
          state_d = ST_BLOCKED;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux, registered below for one-cycle latency
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_PERIOD: readdata_d = {16'd0, period_q};
      ADDR_DUTY:   readdata_d = {16'd0, duty_q};
      ADDR_CTRL:   readdata_d = {30'd0, sens_req_q, enable_q};
      ADDR_STATUS: readdata_d = pack_status(pos_q, at_min_q, at_max_q, state_q);
      default:     readdata_d = 32'd0;
    endcase
  end

  // Driving the generator from the next state cuts PWM on the cycle a stop is taken
  assign run_s = (state_d == ST_RUN);

  // All controller state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q        <= 16'd0;
      duty_q          <= 16'd0;
      enable_q        <= 1'b0;
      sens_req_q      <= 1'b0;
      sens_req_prev_q <= 1'b0;
      pos_q           <= 12'd0;
      at_min_q        <= 1'b0;
      at_max_q        <= 1'b0;
      state_q         <= ST_IDLE;
      dead_cnt_q      <= DEAD_W'(0);
      sens_out_q      <= 1'b0;
      butee_q         <= 1'b0;
      readdata_q      <= 32'd0;
    end else begin
      period_q        <= period_d;
      duty_q          <= duty_d;
      enable_q        <= enable_d;
      sens_req_q      <= sens_req_d;
      sens_req_prev_q <= sens_req_q;
      pos_q           <= pos_d;
      at_min_q        <= at_min_d;
      at_max_q        <= at_max_d;
      state_q         <= state_d;
      dead_cnt_q      <= dead_cnt_d;
      sens_out_q      <= sens_out_d;
      butee_q         <= (state_d == ST_BLOCKED);
      readdata_q      <= readdata_d;
    end
  end

  verin_pwm_gen u_pwm_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run_i    (run_s),
    .period_i (period_q),
    .duty_i   (duty_q),
    .pwm_o    (pwm_out)
  );

  assign readdata  = readdata_q;
  assign sens_out  = sens_out_q;
  assign butee_irq = butee_q;

endmodule

// File: tb/tb_verin_pwm_ctrl.sv
// Directed bench for verin_pwm_ctrl: register access, PWM timing, dead-time,
// end-stop blocking, degenerate period and asynchronous reset.
module tb_verin_pwm_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [11:0] position = 12'd0;
  logic        pos_valid = 1'b0;
  logic        pwm_out;
  logic        sens_out;
  logic        butee_irq;

  int errors = 0;
  int checks = 0;
  logic [31:0] rdv;
  int hi;

  always #5 clk = ~clk;

  verin_pwm_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .position   (position),
    .pos_valid  (pos_valid),
    .pwm_out    (pwm_out),
    .sens_out   (sens_out),
    .butee_irq  (butee_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic put_pos(input logic [11:0] p);
    @(negedge clk);
    position = p; pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
  endtask

  task automatic count_high(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      c += int'(pwm_out);
    end
  endtask

  // Stops at the first sample where pwm_out has just risen (start of a period)
  task automatic wait_rise(input string tag);
    bit low_seen = 1'b0;
    bit rose = 1'b0;
    for (int i = 0; i < 400 && !rose; i++) begin
      @(negedge clk);
      if (!pwm_out) low_seen = 1'b1;
      else if (low_seen) rose = 1'b1;
    end
    check(tag, 32'(rose), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_sens", 32'(sens_out), 32'd0);
    check("rst_irq", 32'(butee_irq), 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), rdv);
      check($sformatf("rst_read%0d", a), rdv, 32'd0);
    end
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3, rdv);
    check("status_ro", rdv, 32'd0);

    // PERIOD=100, DUTY=25, enable: 50 dead cycles then 25 high / 75 low
    wr(2'd0, 32'd100);
    wr(2'd1, 32'd25);
    rd(2'd0, rdv);
    check("rd_period", rdv, 32'd100);
    rd(2'd1, rdv);
    check("rd_duty", rdv, 32'd25);
    wr(2'd2, 32'h1);
    count_high(50, hi);
    check("dead_low", 32'(hi), 32'd0);
    @(negedge clk);
    check("first_rise", 32'(pwm_out), 32'd1);
    count_high(24, hi);
    check("high_25", 32'(hi), 32'd24);
    @(negedge clk);
    check("fall_at_25", 32'(pwm_out), 32'd0);
    count_high(74, hi);
    check("low_75", 32'(hi), 32'd0);
    @(negedge clk);
    check("period_100", 32'(pwm_out), 32'd1);
    rd(2'd3, rdv);
    check("status_run", rdv, 32'h0000_8000);
    rd(2'd2, rdv);
    check("rd_ctrl", rdv, 32'h1);

    // Duty change mid-period only applies from the next period
    wait_rise("align_duty");
    wr(2'd1, 32'd60);
    count_high(97, hi);
    check("duty_keep25", 32'(hi), 32'd22);
    count_high(100, hi);
    check("duty_new60", 32'(hi), 32'd60);

    // Reversal while high: PWM drops at once, sens flips after 50 dead cycles
    wait_rise("align_rev");
    wr(2'd2, 32'h3);
    check("rev_before", 32'(pwm_out), 32'd1);
    @(negedge clk);
    check("rev_cut", 32'(pwm_out), 32'd0);
    count_high(49, hi);
    check("rev_dead_low", 32'(hi), 32'd0);
    check("rev_sens_old", 32'(sens_out), 32'd0);
    @(negedge clk);
    check("rev_sens_new", 32'(sens_out), 32'd1);
    check("rev_resume", 32'(pwm_out), 32'd1);

    // End-stop at POS_MAX while extending
    put_pos(12'd3900);
    @(negedge clk);
    check("blk_irq", 32'(butee_irq), 32'd1);
    check("blk_pwm", 32'(pwm_out), 32'd0);
    rd(2'd3, rdv);
    check("blk_status", rdv, 32'h0000_EF3C);
    put_pos(12'd3800);
    count_high(10, hi);
    check("blk_hold_pwm", 32'(hi), 32'd0);
    check("blk_hold_irq", 32'(butee_irq), 32'd1);
    rd(2'd3, rdv);
    check("blk_hold_status", rdv, 32'h0000_CED8);
    wr(2'd2, 32'h1);
    @(negedge clk);
    check("unblk_irq", 32'(butee_irq), 32'd0);
    count_high(49, hi);
    check("unblk_dead", 32'(hi), 32'd0);
    check("unblk_sens_old", 32'(sens_out), 32'd1);
    @(negedge clk);
    check("unblk_sens_new", 32'(sens_out), 32'd0);
    check("unblk_pwm", 32'(pwm_out), 32'd1);
    rd(2'd3, rdv);
    check("unblk_status", rdv, 32'h0000_8ED8);

    // Disable, then zero period still reaches RUN with PWM held low
    wr(2'd2, 32'h0);
    @(negedge clk);
    check("dis_pwm", 32'(pwm_out), 32'd0);
    rd(2'd3, rdv);
    check("dis_status", rdv, 32'h0000_0ED8);
    wr(2'd0, 32'd0);
    wr(2'd2, 32'h1);
    count_high(60, hi);
    check("p0_low", 32'(hi), 32'd0);
    rd(2'd3, rdv);
    check("p0_status", rdv, 32'h0000_8ED8);

    // Duty >= period gives 100 % high
    wr(2'd1, 32'd100);
    wr(2'd0, 32'd100);
    @(negedge clk);
    count_high(100, hi);
    check("full_duty", 32'(hi), 32'd100);

    // Extend at full duty, then asynchronous reset between clock edges
    wr(2'd2, 32'h3);
    repeat (60) @(negedge clk);
    check("pre_rst_pwm", 32'(pwm_out), 32'd1);
    check("pre_rst_sens", 32'(sens_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_pwm", 32'(pwm_out), 32'd0);
    check("arst_sens", 32'(sens_out), 32'd0);
    check("arst_irq", 32'(butee_irq), 32'd0);
    check("arst_rdata", readdata, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
